// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU-control decode stage.
//   - RV32 major opcode constants and the func7 patterns the decoder tests for
//   - alu_op_e: ALU operation encoding, M-extension codes always present so the
//     encoding is stable whether or not ALU_CTRL_MULDIV_EN is defined
//   - CtrlWMin: smallest alu_op width that can hold every code
package alu_ctrl_pkg;

    localparam int unsigned CtrlWMin = 5;

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcBranch = 7'b1100011;

    localparam logic [6:0] F7Base   = 7'b0000000;
    localparam logic [6:0] F7Alt    = 7'b0100000;
    localparam logic [6:0] F7MulDiv = 7'b0000001;

    typedef enum logic [4:0] {
        AluAnd    = 5'd0,
        AluOr     = 5'd1,
        AluAdd    = 5'd2,
        AluSub    = 5'd3,
        AluBlt    = 5'd4,
        AluBge    = 5'd5,
        AluBeq    = 5'd6,
        AluXor    = 5'd7,
        AluSll    = 5'd8,
        AluSrl    = 5'd9,
        AluSra    = 5'd10,
        AluSlt    = 5'd11,
        AluSltu   = 5'd12,
        AluBne    = 5'd13,
        AluBltu   = 5'd14,
        AluBgeu   = 5'd15,
        AluPassB  = 5'd16,
        AluMul    = 5'd17,
        AluMulh   = 5'd18,
        AluMulhsu = 5'd19,
        AluMulhu  = 5'd20,
        AluDiv    = 5'd21,
        AluDivu   = 5'd22,
        AluRem    = 5'd23,
        AluRemu   = 5'd24
    } alu_op_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational RV32 ALU-control decoder.
//   opcode  in  7  instruction[6:0]
//   func3   in  3  instruction[14:12]
//   func7   in  7  instruction[31:25]
//   op      out 5  ALU operation code (ADD whenever illegal)
//   illegal out 1  encoding not supported
// Build option: ALU_CTRL_MULDIV_EN enables the M-extension R-type encodings;
// without it they decode as illegal.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    output alu_op_e    op,
    output logic       illegal
);

    // Illegal paths only raise the flag; op keeps its ADD default.
    always_comb begin
        op      = AluAdd;
        illegal = 1'b0;
        unique case (opcode)
            OpcOp: begin
                if (func7 == F7Base) begin
                    unique case (func3)
                        3'b000: op = AluAdd;
                        3'b001: op = AluSll;
                        3'b010: op = AluSlt;
                        3'b011: op = AluSltu;
                        3'b100: op = AluXor;
                        3'b101: op = AluSrl;
                        3'b110: op = AluOr;
                        3'b111: op = AluAnd;
                    endcase
                end else if (func7 == F7Alt) begin
                    unique case (func3)
                        3'b000:  op = AluSub;
                        3'b101:  op = AluSra;
                        default: illegal = 1'b1;
                    endcase
                end else if (func7 == F7MulDiv) begin
`ifdef ALU_CTRL_MULDIV_EN
                    unique case (func3)
                        3'b000: op = AluMul;
                        3'b001: op = AluMulh;
                        3'b010: op = AluMulhsu;
                        3'b011: op = AluMulhu;
                        3'b100: op = AluDiv;
                        3'b101: op = AluDivu;
                        3'b110: op = AluRem;
                        3'b111: op = AluRemu;
                    endcase
`else
                    illegal = 1'b1;
`endif
                end else begin
                    illegal = 1'b1;
                end
            end
            OpcOpImm: begin
                // func7 only carries meaning for the shift-immediate forms.
                unique case (func3)
                    3'b000: op = AluAdd;
                    3'b010: op = AluSlt;
                    3'b011: op = AluSltu;
                    3'b100: op = AluXor;
                    3'b110: op = AluOr;
                    3'b111: op = AluAnd;
                    3'b001: begin
                        if (func7 == F7Base) op = AluSll;
                        else                 illegal = 1'b1;
                    end
                    3'b101: begin
                        if (func7 == F7Alt)       op = AluSra;
                        else if (func7 == F7Base) op = AluSrl;
                        else                      illegal = 1'b1;
                    end
                endcase
            end
            OpcLoad, OpcStore, OpcJal, OpcAuipc: op = AluAdd;
            OpcJalr: begin
                if (func3 != 3'b000) illegal = 1'b1;
            end
            OpcLui: op = AluPassB;
            OpcBranch: begin
                unique case (func3)
                    3'b000:  op = AluBeq;
                    3'b001:  op = AluBne;
                    3'b100:  op = AluBlt;
                    3'b101:  op = AluBge;
                    3'b110:  op = AluBltu;
                    3'b111:  op = AluBgeu;
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_stage.sv
// Registered, handshaked ALU-control decode stage (decode -> execute).
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  upstream handshake; in_ready is registered
//   opcode/func3/func7   instruction fields to decode
//   in_tag / out_tag     opaque tag carried alongside each result
//   out_valid/out_ready  downstream handshake
//   alu_op, illegal      registered decode result
//   illegal_cnt          saturating count of accepted illegal encodings
//   clr_cnt              synchronous clear of illegal_cnt (wins over increment)
// Build option: ALU_CTRL_MULDIV_EN (see alu_ctrl_decode).
// Storage is a main register feeding the outputs plus one skid register that
// catches the entry accepted while main is stalled.
module alu_ctrl_stage
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned CTRL_W = 5,
    parameter int unsigned TAG_W  = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [2:0]        func3,
    input  logic [6:0]        func7,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] alu_op,
    output logic              illegal,
    output logic [TAG_W-1:0]  out_tag,
    output logic [CNT_W-1:0]  illegal_cnt,
    input  logic              clr_cnt
);

    if (CTRL_W < CtrlWMin) begin : g_ctrl_w_check
        $error("alu_ctrl_stage: CTRL_W must be at least 5");
    end

    typedef struct packed {
        logic [CTRL_W-1:0] op;
        logic              illegal;
        logic [TAG_W-1:0]  tag;
    } entry_t;

    alu_op_e dec_op;
    logic    dec_illegal;

    alu_ctrl_decode u_decode (
        .opcode  (opcode),
        .func3   (func3),
        .func7   (func7),
        .op      (dec_op),
        .illegal (dec_illegal)
    );

    entry_t           main_q, main_d, skid_q, skid_d, new_entry;
    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_xfer, out_xfer;

    assign new_entry = '{op: CTRL_W'(dec_op), illegal: dec_illegal, tag: in_tag};

    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = main_valid_q & out_ready;

    // in_ready_q tracks !skid_valid_q, so an input can never arrive while skid
    // is full; that case needs no handling below.
    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (out_xfer) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (in_xfer) begin
                main_d = new_entry;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_xfer) begin
            if (!main_valid_q) begin
                main_d       = new_entry;
                main_valid_d = 1'b1;
            end else begin
                skid_d       = new_entry;
                skid_valid_d = 1'b1;
            end
        end
        in_ready_d = ~skid_valid_d;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (in_xfer && dec_illegal && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q       <= '0;
            main_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            cnt_q        <= '0;
        end else begin
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            cnt_q        <= cnt_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = main_valid_q;
    assign alu_op      = main_q.op;
    assign illegal     = main_q.illegal;
    assign out_tag     = main_q.tag;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Self-checking bench for alu_ctrl_stage. Expected results are queued when an
// input transfer happens and popped when the DUT performs an output transfer.
// The counter is built 8 bits wide so saturation is reached in a few hundred
// cycles.
module tb_alu_ctrl_stage;

    localparam int unsigned CTRL_W = 5;
    localparam int unsigned TAG_W  = 8;
    localparam int unsigned CNT_W  = 8;

    localparam logic [6:0] R  = 7'b0110011;
    localparam logic [6:0] I  = 7'b0010011;
    localparam logic [6:0] BR = 7'b1100011;

    logic              clk, rst_n;
    logic              in_valid, in_ready;
    logic [6:0]        opcode, func7;
    logic [2:0]        func3;
    logic [TAG_W-1:0]  in_tag, out_tag;
    logic              out_valid, out_ready;
    logic [CTRL_W-1:0] alu_op;
    logic              illegal;
    logic [CNT_W-1:0]  illegal_cnt;
    logic              clr_cnt;

    alu_ctrl_stage #(
        .CTRL_W (CTRL_W),
        .TAG_W  (TAG_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .opcode      (opcode),
        .func3       (func3),
        .func7       (func7),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_op      (alu_op),
        .illegal     (illegal),
        .out_tag     (out_tag),
        .illegal_cnt (illegal_cnt),
        .clr_cnt     (clr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [CTRL_W-1:0] op;
        logic              ill;
        logic [TAG_W-1:0]  tag;
    } exp_t;

    typedef struct packed {
        logic [6:0]        opc;
        logic [2:0]        f3;
        logic [6:0]        f7;
        logic [CTRL_W-1:0] op;
        logic              ill;
    } vec_t;

    exp_t             sb_q[$];
    vec_t             vecs[$];
    int               total, bad;
    logic [CNT_W-1:0] exp_cnt;
    logic [CTRL_W-1:0] cur_op;
    logic             cur_ill;
    logic             hold_prev;
    logic [CTRL_W-1:0] hold_op;
    logic             hold_ill;
    logic [TAG_W-1:0] hold_tag;

    task automatic drive(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [TAG_W-1:0] tag,
                         input logic [CTRL_W-1:0] eop, input logic eill);
        in_valid = v;
        opcode   = opc;
        func3    = f3;
        func7    = f7;
        in_tag   = tag;
        cur_op   = eop;
        cur_ill  = eill;
    endtask

    // One clock cycle, called just after a falling edge: checks the stalled
    // output against last cycle, scoreboards any output transfer, records any
    // input transfer, then advances to the next falling edge.
    task automatic tick();
        exp_t e;
        if (hold_prev) begin
            total++;
            if (out_valid !== 1'b1 || alu_op !== hold_op || illegal !== hold_ill ||
                out_tag !== hold_tag) begin
                bad++;
                $display("FAIL hold_stable: valid=%b op=%0d ill=%b tag=%h, need valid=1 op=%0d ill=%b tag=%h",
                         out_valid, alu_op, illegal, out_tag, hold_op, hold_ill, hold_tag);
            end
        end
        hold_prev = out_valid && !out_ready;
        hold_op   = alu_op;
        hold_ill  = illegal;
        hold_tag  = out_tag;
        if (out_valid && out_ready) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL sb_spurious: got op=%0d ill=%b tag=%h, need no output",
                         alu_op, illegal, out_tag);
            end else begin
                e = sb_q.pop_front();
                if (alu_op !== e.op || illegal !== e.ill || out_tag !== e.tag) begin
                    bad++;
                    $display("FAIL sb_result: got op=%0d ill=%b tag=%h, need op=%0d ill=%b tag=%h",
                             alu_op, illegal, out_tag, e.op, e.ill, e.tag);
                end
            end
        end
        if (in_valid && in_ready) sb_q.push_back('{op: cur_op, ill: cur_ill, tag: in_tag});
        if (clr_cnt) exp_cnt = '0;
        else if (in_valid && in_ready && cur_ill && exp_cnt != {CNT_W{1'b1}}) exp_cnt++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 12 && sb_q.size() != 0; i++) tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 7'd0, 3'd0, 7'd0, 8'h00, 5'd2, 1'b0);
        out_ready = 1'b0;
        clr_cnt   = 1'b0;
        exp_cnt   = '0;
        hold_prev = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || alu_op !== 5'd0 || illegal !== 1'b0 || out_tag !== 8'h00 ||
            illegal_cnt !== 8'h00) begin
            bad++;
            $display("FAIL reset_state: valid=%b op=%0d ill=%b tag=%h cnt=%h, need all zero",
                     out_valid, alu_op, illegal, out_tag, illegal_cnt);
        end
        rst_n = 1'b1;
        tick();
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b need 1", in_ready);
        end
    endtask

    task automatic test_rtype_sub();
        out_ready = 1'b1;
        drive(1'b1, R, 3'b000, 7'b0100000, 8'h5A, 5'd3, 1'b0);
        tick();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || alu_op !== 5'd3 || illegal !== 1'b0 || out_tag !== 8'h5A) begin
            bad++;
            $display("FAIL sub_latency: valid=%b op=%0d ill=%b tag=%h, need 1 3 0 5a",
                     out_valid, alu_op, illegal, out_tag);
        end
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL sub_drained: out_valid=%b need 0", out_valid);
        end
    endtask

    task automatic test_decode();
        int n_ill;
        int idx;
        logic acc;
        vecs.delete();
        vecs.push_back('{R, 3'b000, 7'b0000000, 5'd2, 1'b0});
        vecs.push_back('{R, 3'b001, 7'b0000000, 5'd8, 1'b0});
        vecs.push_back('{R, 3'b010, 7'b0000000, 5'd11, 1'b0});
        vecs.push_back('{R, 3'b011, 7'b0000000, 5'd12, 1'b0});
        vecs.push_back('{R, 3'b100, 7'b0000000, 5'd7, 1'b0});
        vecs.push_back('{R, 3'b101, 7'b0000000, 5'd9, 1'b0});
        vecs.push_back('{R, 3'b110, 7'b0000000, 5'd1, 1'b0});
        vecs.push_back('{R, 3'b111, 7'b0000000, 5'd0, 1'b0});
        vecs.push_back('{R, 3'b101, 7'b0100000, 5'd10, 1'b0});
        vecs.push_back('{R, 3'b001, 7'b0100000, 5'd2, 1'b1});
        vecs.push_back('{R, 3'b111, 7'b0100000, 5'd2, 1'b1});
        vecs.push_back('{R, 3'b000, 7'b1111111, 5'd2, 1'b1});
`ifdef ALU_CTRL_MULDIV_EN
        vecs.push_back('{R, 3'b000, 7'b0000001, 5'd17, 1'b0});
        vecs.push_back('{R, 3'b100, 7'b0000001, 5'd21, 1'b0});
        vecs.push_back('{R, 3'b111, 7'b0000001, 5'd24, 1'b0});
`else
        vecs.push_back('{R, 3'b000, 7'b0000001, 5'd2, 1'b1});
        vecs.push_back('{R, 3'b100, 7'b0000001, 5'd2, 1'b1});
        vecs.push_back('{R, 3'b111, 7'b0000001, 5'd2, 1'b1});
`endif
        vecs.push_back('{I, 3'b000, 7'b1010101, 5'd2, 1'b0});
        vecs.push_back('{I, 3'b010, 7'b1111111, 5'd11, 1'b0});
        vecs.push_back('{I, 3'b011, 7'b0000000, 5'd12, 1'b0});
        vecs.push_back('{I, 3'b100, 7'b0100000, 5'd7, 1'b0});
        vecs.push_back('{I, 3'b110, 7'b0000001, 5'd1, 1'b0});
        vecs.push_back('{I, 3'b111, 7'b0000000, 5'd0, 1'b0});
        vecs.push_back('{I, 3'b001, 7'b0000000, 5'd8, 1'b0});
        vecs.push_back('{I, 3'b001, 7'b0100000, 5'd2, 1'b1});
        vecs.push_back('{I, 3'b101, 7'b0100000, 5'd10, 1'b0});
        vecs.push_back('{I, 3'b101, 7'b0000000, 5'd9, 1'b0});
        vecs.push_back('{I, 3'b101, 7'b0000001, 5'd2, 1'b1});
        vecs.push_back('{7'b0110111, 3'b011, 7'b1100110, 5'd16, 1'b0});
        vecs.push_back('{7'b0000011, 3'b010, 7'b0000000, 5'd2, 1'b0});
        vecs.push_back('{7'b0100011, 3'b010, 7'b0000000, 5'd2, 1'b0});
        vecs.push_back('{7'b1101111, 3'b101, 7'b0101010, 5'd2, 1'b0});
        vecs.push_back('{7'b1100111, 3'b000, 7'b0000000, 5'd2, 1'b0});
        vecs.push_back('{7'b1100111, 3'b001, 7'b0000000, 5'd2, 1'b1});
        vecs.push_back('{7'b0010111, 3'b110, 7'b0000000, 5'd2, 1'b0});
        vecs.push_back('{BR, 3'b000, 7'b0000000, 5'd6, 1'b0});
        vecs.push_back('{BR, 3'b001, 7'b0000000, 5'd13, 1'b0});
        vecs.push_back('{BR, 3'b100, 7'b0000000, 5'd4, 1'b0});
        vecs.push_back('{BR, 3'b101, 7'b0000000, 5'd5, 1'b0});
        vecs.push_back('{BR, 3'b110, 7'b0000000, 5'd14, 1'b0});
        vecs.push_back('{BR, 3'b111, 7'b0000000, 5'd15, 1'b0});
        vecs.push_back('{BR, 3'b010, 7'b0000000, 5'd2, 1'b1});
        vecs.push_back('{BR, 3'b011, 7'b0000000, 5'd2, 1'b1});
        vecs.push_back('{7'b0000000, 3'b000, 7'b0000000, 5'd2, 1'b1});
        vecs.push_back('{7'b1111111, 3'b111, 7'b1111111, 5'd2, 1'b1});

        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        n_ill = 0;
        idx   = 0;
        // Stall the output on a few cycles so entries pass through skid too.
        for (int cyc = 0; cyc < 200 && idx < vecs.size(); cyc++) begin
            out_ready = (cyc % 5) != 3;
            drive(1'b1, vecs[idx].opc, vecs[idx].f3, vecs[idx].f7, 8'(idx + 8'h80),
                  vecs[idx].op, vecs[idx].ill);
            acc = in_valid && in_ready;
            tick();
            if (acc) begin
                if (vecs[idx].ill) n_ill++;
                idx++;
            end
        end
        drain();
        total++;
        if (idx != vecs.size() || sb_q.size() != 0) begin
            bad++;
            $display("FAIL decode_flow: sent=%0d left=%0d, need sent=%0d left=0",
                     idx, sb_q.size(), vecs.size());
        end
        total++;
        if (illegal_cnt !== 8'(n_ill)) begin
            bad++;
            $display("FAIL decode_cnt: got %0d need %0d", illegal_cnt, n_ill);
        end
    endtask

    task automatic test_illegal_cnt();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        total++;
        if (illegal_cnt !== 8'h00) begin
            bad++;
            $display("FAIL cnt_clear: got %h need 00", illegal_cnt);
        end
        out_ready = 1'b1;
        drive(1'b1, BR, 3'b010, 7'b0000000, 8'h77, 5'd2, 1'b1);
        tick();
        in_valid = 1'b0;
        total++;
        if (illegal_cnt !== 8'h01 || illegal !== 1'b1 || alu_op !== 5'd2) begin
            bad++;
            $display("FAIL cnt_first: cnt=%h ill=%b op=%0d, need 01 1 2",
                     illegal_cnt, illegal, alu_op);
        end
        tick();
        for (int i = 0; i < 260; i++) begin
            drive(1'b1, 7'b1111111, 3'(i), 7'd0, 8'(i), 5'd2, 1'b1);
            tick();
        end
        drain();
        total++;
        if (illegal_cnt !== 8'hFF || exp_cnt !== 8'hFF) begin
            bad++;
            $display("FAIL cnt_saturate: got %h need ff (model %h)", illegal_cnt, exp_cnt);
        end
        drive(1'b1, BR, 3'b011, 7'd0, 8'hEE, 5'd2, 1'b1);
        tick();
        in_valid = 1'b0;
        total++;
        if (illegal_cnt !== 8'hFF) begin
            bad++;
            $display("FAIL cnt_hold_max: got %h need ff", illegal_cnt);
        end
        clr_cnt = 1'b1;
        drive(1'b1, BR, 3'b010, 7'd0, 8'hEF, 5'd2, 1'b1);
        tick();
        clr_cnt  = 1'b0;
        in_valid = 1'b0;
        total++;
        if (illegal_cnt !== 8'h00) begin
            bad++;
            $display("FAIL cnt_clr_priority: got %h need 00", illegal_cnt);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(1'b1, R, 3'b000, 7'b0000000, 8'h01, 5'd2, 1'b0);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ready1: got %b need 1", in_ready);
        end
        tick();
        drive(1'b1, R, 3'b100, 7'b0000000, 8'h02, 5'd7, 1'b0);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ready2: got %b need 1", in_ready);
        end
        tick();
        drive(1'b1, R, 3'b000, 7'b0100000, 8'h03, 5'd3, 1'b0);
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_ready3: got %b need 0", in_ready);
        end
        tick();
        tick();
        total++;
        if (in_ready !== 1'b0 || out_tag !== 8'h01) begin
            bad++;
            $display("FAIL b2b_stalled: in_ready=%b tag=%h, need 0 01", in_ready, out_tag);
        end
        out_ready = 1'b1;
        tick();
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_reopen: got %b need 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        tick();
        total++;
        if (sb_q.size() != 0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_order: left=%0d out_valid=%b, need 0 0", sb_q.size(), out_valid);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(1'b1, BR, 3'b010, 7'd0, 8'hA1, 5'd2, 1'b1);
        tick();
        drive(1'b1, 7'b0000000, 3'd0, 7'd0, 8'hA2, 5'd2, 1'b1);
        tick();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || illegal_cnt !== 8'h02) begin
            bad++;
            $display("FAIL rst_mid_full: valid=%b ready=%b cnt=%h, need 1 0 02",
                     out_valid, in_ready, illegal_cnt);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || illegal_cnt !== 8'h00 || alu_op !== 5'd0 ||
            illegal !== 1'b0 || out_tag !== 8'h00) begin
            bad++;
            $display("FAIL rst_mid_async: valid=%b cnt=%h op=%0d ill=%b tag=%h, need all zero",
                     out_valid, illegal_cnt, alu_op, illegal, out_tag);
        end
        sb_q.delete();
        exp_cnt   = '0;
        hold_prev = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_release: ready=%b valid=%b, need 1 0", in_ready, out_valid);
        end
        out_ready = 1'b1;
        drive(1'b1, 7'b0110111, 3'd0, 7'd0, 8'h3C, 5'd16, 1'b0);
        tick();
        drain();
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL rst_mid_resume: left=%0d need 0", sb_q.size());
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_rtype_sub();
        test_decode();
        test_illegal_cnt();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
